multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Steps the shared datapath (single memory, single ALU) through Fetch/Decode/Execute/Memory/Writeback.
- Includes a memory-ready handshake so that slow memory stalls the sequence.
- Sits beside the ALU decoder; produces every per-state enable and mux select except ALUControl.

---
 rtl/riscv_pkg.sv | 142 ++++++++++++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/instrdec.sv | 19 +
 rtl/multicycle_ctrl.sv | 78 +++++++
 tb/tb_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I control path.
package riscv_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [ST_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } statetype_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    // Per-state control word; fetch and retire_rdy are qualified by mem_ready downstream.
    typedef struct packed {
        logic             pcupdate;
        logic             branch;
        logic             fetch;
        logic             adrsrc;
        logic             memwrite;
        logic             regwrite;
        logic             retire;
        logic             retire_rdy;
        logic [SEL_W-1:0] resultsrc;
        logic [SEL_W-1:0] alusrca;
        logic [SEL_W-1:0] alusrcb;
        logic [SEL_W-1:0] aluop;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input statetype_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch     = 1'b1;
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                c.alusrca = SRCA_OLDPC;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            MEMADR: begin
                c.alusrca = SRCA_RD1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            MEMREAD: begin
                c.adrsrc    = 1'b1;
                c.resultsrc = RES_ALUOUT;
            end
            MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
                c.retire    = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc     = 1'b1;
                c.resultsrc  = RES_ALUOUT;
                c.memwrite   = 1'b1;
                c.retire_rdy = 1'b1;
            end
            EXECUTER: begin
                c.alusrca = SRCA_RD1;
                c.alusrcb = SRCB_RD2;
                c.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regwrite  = 1'b1;
                c.retire    = 1'b1;
            end
            EXECUTEI: begin
                c.alusrca = SRCA_RD1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_FUNCT;
            end
            JAL: begin
                c.alusrca   = SRCA_OLDPC;
                c.alusrcb   = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.resultsrc = RES_ALUOUT;
                c.pcupdate  = 1'b1;
            end
            BEQ: begin
                c.alusrca   = SRCA_RD1;
                c.alusrcb   = SRCB_RD2;
                c.aluop     = ALUOP_SUB;
                c.resultsrc = RES_ALUOUT;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multicycle_ctrl_if;
    import riscv_pkg::*;

    logic [OP_W-1:0]  op;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [SEL_W-1:0] ResultSrc;
    logic [SEL_W-1:0] ALUSrcA;
    logic [SEL_W-1:0] ALUSrcB;
    logic [SEL_W-1:0] ALUOp;
    logic [SEL_W-1:0] ImmSrc;
    logic             RegWrite;
    logic             illegal_op;
    logic             retire;
    logic [ST_W-1:0]  state_o;

    modport master (
        input  op, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, illegal_op, retire, state_o
    );

    modport slave (
        output op, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, illegal_op, retire, state_o
    );

endinterface

// File: rtl/instrdec.sv
// Immediate-format select from the opcode, independent of FSM state.
module instrdec
    import riscv_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [SEL_W-1:0] immsrc
);

    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core with memory-ready stalling.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
)
(
    input logic              clk,
    input logic              reset,
    multicycle_ctrl_if.master bus
);

    statetype_t state;
    statetype_t state_n;
    ctrl_t      ctl;
    logic       rdy;

    assign rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:    state_n = rdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_R:         state_n = EXECUTER;
                    OP_I:         state_n = EXECUTEI;
                    OP_JAL:       state_n = JAL;
                    OP_BEQ:       state_n = BEQ;
                    default:      state_n = FETCH;
                endcase
            end
            MEMADR:   state_n = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_n = rdy ? MEMWB : MEMREAD;
            MEMWB:    state_n = FETCH;
            MEMWRITE: state_n = rdy ? FETCH : MEMWRITE;
            EXECUTER: state_n = ALUWB;
            ALUWB:    state_n = FETCH;
            EXECUTEI: state_n = ALUWB;
            JAL:      state_n = ALUWB;
            BEQ:      state_n = FETCH;
            default:  state_n = FETCH;
        endcase
    end

    // Control word is registered alongside the state so it always matches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctl   <= state_ctrl(FETCH);
        end else begin
            state <= state_n;
            ctl   <= state_ctrl(state_n);
        end
    end

    // Write strobes are masked by reset so an asserted reset kills them at once.
    assign bus.PCWrite    = ~reset & (ctl.pcupdate | (ctl.fetch & rdy) | (ctl.branch & bus.Zero));
    assign bus.IRWrite    = ~reset & ctl.fetch & rdy;
    assign bus.MemWrite   = ~reset & ctl.memwrite;
    assign bus.RegWrite   = ~reset & ctl.regwrite;
    assign bus.retire     = ~reset & (ctl.retire | (ctl.retire_rdy & rdy));
    assign bus.illegal_op = ~reset & (state == DECODE) & ~op_legal(bus.op);

    assign bus.AdrSrc    = ctl.adrsrc;
    assign bus.ResultSrc = ctl.resultsrc;
    assign bus.ALUSrcA   = ctl.alusrca;
    assign bus.ALUSrcB   = ctl.alusrcb;
    assign bus.ALUOp     = ctl.aluop;
    assign bus.state_o   = ST_W'(state);

    instrdec u_instrdec (
        .op     (bus.op),
        .immsrc (bus.ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl against a per-instruction phase model.
module tb_multicycle_ctrl;

    typedef int q_t[$];

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Instruction as the ordered list of states it visits.
    function automatic q_t seq_of(input logic [6:0] op);
        q_t q;
        case (op)
            T_LW:    q = '{0, 1, 2, 3, 4};
            T_SW:    q = '{0, 1, 2, 5};
            T_R:     q = '{0, 1, 6, 7};
            T_I:     q = '{0, 1, 8, 7};
            T_JAL:   q = '{0, 1, 9, 7};
            T_BEQ:   q = '{0, 1, 10};
            default: q = '{0, 1};
        endcase
        return q;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
    endfunction

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,illegal_op,retire}
    function automatic logic [16:0] exp_vec(input int s, input logic r, input logic z, input logic [6:0] op);
        logic pcw, adr, memw, irw, regw, ill, ret;
        logic [1:0] res, sa, sb, ao, imm;
        pcw = 0; adr = 0; memw = 0; irw = 0; regw = 0; ill = 0; ret = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; ao = 2'b00;
        imm = (op == T_SW) ? 2'b01 : (op == T_BEQ) ? 2'b10 : (op == T_JAL) ? 2'b11 : 2'b00;
        case (s)
            0:  begin sb = 2'b10; res = 2'b10; irw = r; pcw = r; end
            1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin adr = 1; end
            4:  begin res = 2'b01; regw = 1; ret = 1; end
            5:  begin adr = 1; memw = 1; ret = r; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin regw = 1; ret = 1; end
            8:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            10: begin sa = 2'b10; ao = 2'b01; pcw = z; ret = 1; end
            default: ;
        endcase
        return {pcw, adr, memw, irw, res, sa, sb, ao, imm, regw, ill, ret};
    endfunction

    function automatic logic [16:0] act_vec();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.RegWrite, bus.illegal_op, bus.retire};
    endfunction

    // Runs one instruction from FETCH; called at posedge+1 with state FETCH.
    task automatic run_instr(input string name, input logic [6:0] op, input logic z,
                             input int nf, input int nm);
        q_t   seq;
        int   idx, stall, cycles, total, nstall;
        int   pcw_n, irw_n, ret_n, regw_n, memw_n, ill_n;
        int   exp_pcw, exp_ret, exp_regw, exp_memw;
        bit   waits;
        logic r;
        logic [16:0] ev, av;
        seq = seq_of(op);
        idx = 0; stall = 0; cycles = 0;
        pcw_n = 0; irw_n = 0; ret_n = 0; regw_n = 0; memw_n = 0; ill_n = 0;
        total = seq.size() + nf + ((op == T_LW || op == T_SW) ? nm : 0);
        while (idx < seq.size() && cycles < 100) begin
            waits  = (seq[idx] == 0) || (seq[idx] == 3) || (seq[idx] == 5);
            nstall = (seq[idx] == 0) ? nf : nm;
            r = waits ? logic'(stall >= nstall) : 1'($urandom);
            bus.op        = op;
            bus.mem_ready = r;
            bus.Zero      = (seq[idx] == 10) ? z : 1'($urandom);
            #3;
            checks++;
            if (bus.state_o !== 4'(seq[idx])) begin
                failures++;
                $display("FAIL %s state cyc=%0d got=%0d exp=%0d", name, cycles, bus.state_o, seq[idx]);
            end
            ev = exp_vec(seq[idx], r, bus.Zero, op);
            av = act_vec();
            checks++;
            if (av !== ev) begin
                failures++;
                $display("FAIL %s outputs cyc=%0d got=%b exp=%b", name, cycles, av, ev);
            end
            pcw_n += int'(bus.PCWrite); irw_n += int'(bus.IRWrite); ret_n += int'(bus.retire);
            regw_n += int'(bus.RegWrite); memw_n += int'(bus.MemWrite); ill_n += int'(bus.illegal_op);
            @(posedge clk); #1;
            if (!waits || r) begin idx++; stall = 0; end
            else stall++;
            cycles++;
        end
        exp_pcw  = 1 + ((op == T_JAL) ? 1 : 0) + ((op == T_BEQ && z) ? 1 : 0);
        exp_ret  = is_legal(op) ? 1 : 0;
        exp_regw = (op == T_LW || op == T_R || op == T_I || op == T_JAL) ? 1 : 0;
        exp_memw = (op == T_SW) ? 1 + nm : 0;
        checks++;
        if (cycles !== total) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, cycles, total);
        end
        checks++;
        if ({pcw_n, irw_n, ret_n, regw_n, memw_n, ill_n} !==
            {exp_pcw, 1, exp_ret, exp_regw, exp_memw, is_legal(op) ? 0 : 1}) begin
            failures++;
            $display("FAIL %s counts pcw=%0d irw=%0d ret=%0d regw=%0d memw=%0d ill=%0d exp %0d/1/%0d/%0d/%0d/%0d",
                     name, pcw_n, irw_n, ret_n, regw_n, memw_n, ill_n,
                     exp_pcw, exp_ret, exp_regw, exp_memw, is_legal(op) ? 0 : 1);
        end
        checks++;
        if (bus.state_o !== 4'd0) begin
            failures++;
            $display("FAIL %s end_state got=%0d exp=0", name, bus.state_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.op = T_R; bus.mem_ready = 1'b1; bus.Zero = 1'b1;
        repeat (3) begin
            @(posedge clk); #4;
            checks++;
            if ({bus.state_o, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.retire, bus.illegal_op} !== 10'd0) begin
                failures++;
                $display("FAIL reset_hold st=%0d pcw=%b irw=%b mw=%b rw=%b ret=%b ill=%b exp all 0",
                         bus.state_o, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.retire, bus.illegal_op);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("reset_rtype", T_R, 1'b0, 0, 0);
    endtask

    task automatic test_lw();
        run_instr("lw_stall", T_LW, 1'b0, 2, 3);
    endtask

    task automatic test_sw();
        run_instr("sw", T_SW, 1'b0, 0, 0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", T_BEQ, 1'b1, 0, 0);
        run_instr("beq_not_taken", T_BEQ, 1'b0, 0, 0);
    endtask

    task automatic test_jal();
        run_instr("jal", T_JAL, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal", T_BAD, 1'b0, 1, 0);
    endtask

    task automatic test_reset_mid_memwrite();
        bus.op = T_SW; bus.mem_ready = 1'b1; bus.Zero = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.mem_ready = 1'b0;
        #2;
        checks++;
        if ({bus.state_o, bus.MemWrite} !== {4'd5, 1'b1}) begin
            failures++;
            $display("FAIL mw_before_reset st=%0d mw=%b exp st=5 mw=1", bus.state_o, bus.MemWrite);
        end
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if ({bus.state_o, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.retire} !== 9'd0) begin
            failures++;
            $display("FAIL async_reset st=%0d mw=%b pcw=%b irw=%b rw=%b ret=%b exp all 0",
                     bus.state_o, bus.MemWrite, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.retire);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("after_reset_i", T_I, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6];
        ops = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
        for (int i = 0; i < 24; i++) begin
            run_instr($sformatf("rand%0d", i), ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_memwrite();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
